// File: rtl/hamming74_decoder.sv
// rtl/hamming74_decoder.sv - serial syndrome decoder for the cyclic Hamming(7,4) code, g(x)=x^3+x+1
module hamming74_decoder #(
  parameter logic        CORRECT_EN = 1'b1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       codeword_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       message_out,
  output logic [6:0]       codeword_out,
  output logic [2:0]       syndrome_out,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_CORRECT,
    S_OUTPUT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [6:0]       r_shift;
  logic [2:0]       r_syn;
  logic [2:0]       r_bitcnt;
  logic [3:0]       r_msg;
  logic [6:0]       r_cw;
  logic [2:0]       r_syn_out;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
  logic [6:0]       w_flip;
  logic [6:0]       w_fixed;
  logic             w_syn_nz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (in_valid) w_next = S_SHIFT;
      S_SHIFT:   if (r_bitcnt == 3'd6) w_next = S_CORRECT;
      S_CORRECT: w_next = S_OUTPUT;
      S_OUTPUT:  if (out_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Syndrome value equals x^i mod g(x) for a single error at bit i.
  always_comb begin
    w_flip = 7'b0000000;
    case (r_syn)
      3'b001:  w_flip = 7'b0000001;
      3'b010:  w_flip = 7'b0000010;
      3'b100:  w_flip = 7'b0000100;
      3'b011:  w_flip = 7'b0001000;
      3'b110:  w_flip = 7'b0010000;
      3'b111:  w_flip = 7'b0100000;
      3'b101:  w_flip = 7'b1000000;
      default: w_flip = 7'b0000000;
    endcase
  end

  assign w_syn_nz = |r_syn;
  assign w_fixed  = CORRECT_EN ? (r_shift ^ w_flip) : r_shift;

  // The word rotates left once per SHIFT edge, so after seven edges it is back in place for correction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= 7'd0;
      r_syn     <= 3'd0;
      r_bitcnt  <= 3'd0;
      r_msg     <= 4'd0;
      r_cw      <= 7'd0;
      r_syn_out <= 3'd0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_shift  <= codeword_in;
            r_syn    <= 3'd0;
            r_bitcnt <= 3'd0;
          end
        end
        S_SHIFT: begin
          r_syn    <= {r_syn[1], r_syn[0] ^ r_syn[2], r_shift[6] ^ r_syn[2]};
          r_shift  <= {r_shift[5:0], r_shift[6]};
          r_bitcnt <= r_bitcnt + 3'd1;
        end
        S_CORRECT: begin
          r_msg     <= {w_fixed[6], w_fixed[5], w_fixed[4] ^ w_fixed[6], w_fixed[0]};
          r_cw      <= w_fixed;
          r_syn_out <= r_syn;
          r_err     <= w_syn_nz;
          if (w_syn_nz && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready     = (r_state == S_IDLE);
  assign out_valid    = (r_state == S_OUTPUT);
  assign message_out  = r_msg;
  assign codeword_out = r_cw;
  assign syndrome_out = r_syn_out;
  assign err_flag     = r_err;
  assign err_count    = r_cnt;

endmodule

// File: tb/tb_hamming74_decoder.sv
// tb/tb_hamming74_decoder.sv - directed bench for hamming74_decoder (correcting, detect-only and 2-bit counter instances)
module tb_hamming74_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [6:0] codeword_in;

  logic       in_ready_a, out_valid_a, err_a;
  logic [3:0] msg_a;
  logic [6:0] cw_a;
  logic [2:0] syn_a;
  logic [7:0] cnt_a;

  logic       in_ready_n, out_valid_n, err_n;
  logic [3:0] msg_n;
  logic [6:0] cw_n;
  logic [2:0] syn_n;
  logic [7:0] cnt_n;

  logic       in_ready_s, out_valid_s, err_s;
  logic [3:0] msg_s;
  logic [6:0] cw_s;
  logic [2:0] syn_s;
  logic [1:0] cnt_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hamming74_decoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .codeword_in(codeword_in), .out_valid(out_valid_a), .out_ready(out_ready),
    .message_out(msg_a), .codeword_out(cw_a), .syndrome_out(syn_a),
    .err_flag(err_a), .err_count(cnt_a)
  );

  hamming74_decoder #(.CORRECT_EN(1'b0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n),
    .codeword_in(codeword_in), .out_valid(out_valid_n), .out_ready(out_ready),
    .message_out(msg_n), .codeword_out(cw_n), .syndrome_out(syn_n),
    .err_flag(err_n), .err_count(cnt_n)
  );

  hamming74_decoder #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .codeword_in(codeword_in), .out_valid(out_valid_s), .out_ready(out_ready),
    .message_out(msg_s), .codeword_out(cw_s), .syndrome_out(syn_s),
    .err_flag(err_s), .err_count(cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_out();
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid_a && lat < 40);
    chk("latency", lat, 8);
  endtask

  task automatic accept(input logic [6:0] w);
    int n;
    @(negedge clk);
    in_valid    = 1'b1;
    codeword_in = w;
    n = 0;
    while (!in_ready_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_bound", (n < 40), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send(input logic [6:0] w);
    accept(w);
    wait_out();
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  logic [2:0] syn_tab [7] = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b110, 3'b111, 3'b101};
  logic [6:0] w;
  int         sat_exp;
  int         ov_seen;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; codeword_in = 7'd0;
    #12;
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_msg", msg_a, 0);
    chk("rst_cw", cw_a, 0);
    chk("rst_syn", syn_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_cnt", cnt_a, 0);
    @(negedge clk);
    rst_n = 1'b1;

    send(7'b1000101);
    chk("clean_msg", msg_a, 4'b1011);
    chk("clean_syn", syn_a, 3'b000);
    chk("clean_err", err_a, 0);
    chk("clean_cw", cw_a, 7'b1000101);
    chk("clean_cnt", cnt_a, 0);
    take();

    for (int i = 0; i < 7; i++) begin
      w = 7'b1101001 ^ (7'b0000001 << i);
      send(w);
      chk("sweep_msg", msg_a, 4'b1111);
      chk("sweep_cw", cw_a, 7'b1101001);
      chk("sweep_syn", syn_a, syn_tab[i]);
      chk("sweep_err", err_a, 1);
      chk("sweep_cnt", cnt_a, i + 1);
      chk("sweep_nc_cw", cw_n, w);
      sat_exp = (i + 1 > 3) ? 3 : i + 1;
      chk("sat_cnt", cnt_s, sat_exp);
      take();
    end

    send(7'b1000101);
    @(negedge clk);
    in_valid    = 1'b1;
    codeword_in = 7'b0000000;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", out_valid_a, 1);
      chk("bp_in_ready", in_ready_a, 0);
      chk("bp_msg", msg_a, 4'b1011);
      chk("bp_cw", cw_a, 7'b1000101);
      chk("bp_cnt", cnt_a, 7);
    end
    take();
    chk("bp_release_ready", in_ready_a, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out();
    chk("zero_msg", msg_a, 4'b0000);
    chk("zero_err", err_a, 0);
    chk("zero_cw", cw_a, 7'b0000000);
    take();

    send(7'b1010101);
    chk("nc_syn", syn_n, 3'b110);
    chk("nc_err", err_n, 1);
    chk("nc_cw", cw_n, 7'b1010101);
    chk("nc_msg", msg_n, 4'b1001);
    chk("fix_cw", cw_a, 7'b1000101);
    chk("fix_msg", msg_a, 4'b1011);
    chk("fix_cnt", cnt_a, 8);
    take();

    accept(7'b1010101);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready_a, 1);
    chk("mid_rst_out_valid", out_valid_a, 0);
    chk("mid_rst_cnt", cnt_a, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid_a) ov_seen++;
    end
    chk("mid_rst_no_output", ov_seen, 0);
    send(7'b1000101);
    chk("post_rst_msg", msg_a, 4'b1011);
    chk("post_rst_err", err_a, 0);
    chk("post_rst_cnt", cnt_a, 0);
    take();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
